// File: rtl/dmem_noc_arbiter_4to1.sv
// Four-master to one-slave data-memory NoC arbiter: round-robin grant, one transaction outstanding.
// Define DMEM_NOC_ARB_FIXED_PRIO_EN for fixed priority mn0 > mn1 > mn2 > mn3 instead of round-robin.

package dmem_noc_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        resp_last;
  } mem_resp_t;
endpackage

module dmem_noc_arbiter_4to1
  import dmem_noc_pkg::*;
#(
  parameter logic [1:0] RR_RST_PTR = 2'd3
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      mn0_req_valid,
  output logic      mn0_req_ready,
  input  mem_req_t  mn0_req,
  output logic      mn0_resp_valid,
  input  logic      mn0_resp_ready,
  output mem_resp_t mn0_resp,
  input  logic      mn1_req_valid,
  output logic      mn1_req_ready,
  input  mem_req_t  mn1_req,
  output logic      mn1_resp_valid,
  input  logic      mn1_resp_ready,
  output mem_resp_t mn1_resp,
  input  logic      mn2_req_valid,
  output logic      mn2_req_ready,
  input  mem_req_t  mn2_req,
  output logic      mn2_resp_valid,
  input  logic      mn2_resp_ready,
  output mem_resp_t mn2_resp,
  input  logic      mn3_req_valid,
  output logic      mn3_req_ready,
  input  mem_req_t  mn3_req,
  output logic      mn3_resp_valid,
  input  logic      mn3_resp_ready,
  output mem_resp_t mn3_resp,
  output logic      sn_req_valid,
  input  logic      sn_req_ready,
  output mem_req_t  sn_req,
  input  logic      sn_resp_valid,
  output logic      sn_resp_ready,
  input  mem_resp_t sn_resp
);

  typedef enum logic [1:0] {
    ARB  = 2'b00,
    HOLD = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t     cur_state, next_state;
  logic [1:0] gnt_id, next_gnt_id;
  logic [1:0] sel;
  logic       any_valid;

  logic [3:0] req_valid;
  logic [3:0] resp_ready;
  logic [3:0] req_ready;
  logic [3:0] resp_valid;
  mem_req_t   req_arr [4];

  assign req_valid  = {mn3_req_valid, mn2_req_valid, mn1_req_valid, mn0_req_valid};
  assign resp_ready = {mn3_resp_ready, mn2_resp_ready, mn1_resp_ready, mn0_resp_ready};
  assign req_arr[0] = mn0_req;
  assign req_arr[1] = mn1_req;
  assign req_arr[2] = mn2_req;
  assign req_arr[3] = mn3_req;
  assign any_valid  = |req_valid;

  assign mn0_req_ready  = req_ready[0];
  assign mn1_req_ready  = req_ready[1];
  assign mn2_req_ready  = req_ready[2];
  assign mn3_req_ready  = req_ready[3];
  assign mn0_resp_valid = resp_valid[0];
  assign mn1_resp_valid = resp_valid[1];
  assign mn2_resp_valid = resp_valid[2];
  assign mn3_resp_valid = resp_valid[3];

  // Response payload is broadcast; only resp_valid is steered.
  assign mn0_resp = sn_resp;
  assign mn1_resp = sn_resp;
  assign mn2_resp = sn_resp;
  assign mn3_resp = sn_resp;

`ifdef DMEM_NOC_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) sel = 2'(i);
    end
  end
`else
  logic [1:0] rr_ptr, next_rr_ptr;

  // Search starts just after the last granted master so every requester is served within four grants.
  always_comb begin
    logic found;
    logic [1:0] cand;
    sel   = 2'd0;
    found = 1'b0;
    cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_ptr <= RR_RST_PTR;
    else       rr_ptr <= next_rr_ptr;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_state <= ARB;
      gnt_id    <= 2'd0;
    end else begin
      cur_state <= next_state;
      gnt_id    <= next_gnt_id;
    end
  end

  always_comb begin
    next_state    = cur_state;
    next_gnt_id   = gnt_id;
`ifndef DMEM_NOC_ARB_FIXED_PRIO_EN
    next_rr_ptr   = rr_ptr;
`endif
    sn_req_valid  = 1'b0;
    sn_req        = '0;
    sn_resp_ready = 1'b0;
    req_ready     = 4'b0000;
    resp_valid    = 4'b0000;

    unique case (cur_state)
      ARB: begin
        if (any_valid) begin
          sn_req_valid   = 1'b1;
          sn_req         = req_arr[sel];
          req_ready[sel] = sn_req_ready;
          next_gnt_id    = sel;
          if (sn_req_ready) begin
            next_state = RESP;
`ifndef DMEM_NOC_ARB_FIXED_PRIO_EN
            next_rr_ptr = sel;
`endif
          end else begin
            next_state = HOLD;
          end
        end
      end

      // Selection is frozen so the slave never sees a request change under backpressure.
      HOLD: begin
        sn_req_valid      = req_valid[gnt_id];
        sn_req            = req_arr[gnt_id];
        req_ready[gnt_id] = sn_req_ready;
        if (req_valid[gnt_id] && sn_req_ready) begin
          next_state = RESP;
`ifndef DMEM_NOC_ARB_FIXED_PRIO_EN
          next_rr_ptr = gnt_id;
`endif
        end
      end

      RESP: begin
        resp_valid[gnt_id] = sn_resp_valid;
        sn_resp_ready      = resp_ready[gnt_id];
        if (sn_resp_valid && resp_ready[gnt_id] && sn_resp.resp_last) begin
          next_state = ARB;
        end
      end

      default: begin
        next_state = ARB;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_noc_arbiter_4to1.sv
// Randomized bench for dmem_noc_arbiter_4to1 checked against a transaction-level reference model.

module tb_dmem_noc_arbiter_4to1;
  import dmem_noc_pkg::*;

  localparam int NUM_CYCLES = 4000;
  localparam int CONTENTION_CYCLES = 12;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] m_valid;
  logic [3:0] m_req_ready;
  mem_req_t   m_req [4];
  logic [3:0] m_resp_valid;
  logic [3:0] m_resp_ready;
  mem_resp_t  m_resp [4];
  logic       sn_req_valid;
  logic       sn_req_ready;
  mem_req_t   sn_req;
  logic       sn_resp_valid;
  logic       sn_resp_ready;
  mem_resp_t  sn_resp;

  int checks = 0;
  int errors = 0;

  // Reference model: is a transaction outstanding, is a pending grant locked, who owns it, who was served last.
  bit busy;
  bit locked;
  int owner;
  int last_served;
  int accepted;
  int grant_log [$];

  always #5 clk = ~clk;

  dmem_noc_arbiter_4to1 #(.RR_RST_PTR(2'd3)) dut (
    .clk(clk), .rstn(rstn),
    .mn0_req_valid(m_valid[0]), .mn0_req_ready(m_req_ready[0]), .mn0_req(m_req[0]),
    .mn0_resp_valid(m_resp_valid[0]), .mn0_resp_ready(m_resp_ready[0]), .mn0_resp(m_resp[0]),
    .mn1_req_valid(m_valid[1]), .mn1_req_ready(m_req_ready[1]), .mn1_req(m_req[1]),
    .mn1_resp_valid(m_resp_valid[1]), .mn1_resp_ready(m_resp_ready[1]), .mn1_resp(m_resp[1]),
    .mn2_req_valid(m_valid[2]), .mn2_req_ready(m_req_ready[2]), .mn2_req(m_req[2]),
    .mn2_resp_valid(m_resp_valid[2]), .mn2_resp_ready(m_resp_ready[2]), .mn2_resp(m_resp[2]),
    .mn3_req_valid(m_valid[3]), .mn3_req_ready(m_req_ready[3]), .mn3_req(m_req[3]),
    .mn3_resp_valid(m_resp_valid[3]), .mn3_resp_ready(m_resp_ready[3]), .mn3_resp(m_resp[3]),
    .sn_req_valid(sn_req_valid), .sn_req_ready(sn_req_ready), .sn_req(sn_req),
    .sn_resp_valid(sn_resp_valid), .sn_resp_ready(sn_resp_ready), .sn_resp(sn_resp)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r = {$urandom(), $urandom(), 4'($urandom()), 1'($urandom())};
    return r;
  endfunction

  function automatic int pick_next();
`ifdef DMEM_NOC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (m_valid[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (m_valid[(last_served + k) % 4]) return (last_served + k) % 4;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    busy        = 1'b0;
    locked      = 1'b0;
    owner       = 0;
    last_served = 3;
    accepted    = -1;
  endtask

  task automatic applyStimulus(input bit contention);
    int p;
    p = contention ? 100 : 30;
    for (int i = 0; i < 4; i++) begin
      if (accepted == i) m_valid[i] = 1'b0;
      if (!m_valid[i] && ($urandom_range(0, 99) < p)) begin
        m_valid[i] = 1'b1;
        m_req[i]   = rand_req();
      end
    end
    accepted     = -1;
    sn_req_ready = contention ? 1'b1 : 1'($urandom_range(0, 1));
    sn_resp      = {$urandom(), 1'($urandom()), 1'b0};
    sn_resp.resp_last = contention ? 1'b1 : ($urandom_range(0, 2) == 0);
    if (busy) sn_resp_valid = contention ? 1'b1 : ($urandom_range(0, 9) < 7);
    else      sn_resp_valid = contention ? 1'b0 : ($urandom_range(0, 9) == 0);
    for (int i = 0; i < 4; i++)
      m_resp_ready[i] = contention ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_check_and_step();
    logic [3:0] exp_ready;
    logic [3:0] exp_rvalid;
    logic       exp_snv;
    logic       exp_srr;
    int         ch;
    exp_ready  = '0;
    exp_rvalid = '0;
    exp_snv    = 1'b0;
    exp_srr    = 1'b0;
    ch         = -1;
    if (busy) begin
      exp_rvalid[owner] = sn_resp_valid;
      exp_srr           = m_resp_ready[owner];
    end else begin
      ch = locked ? owner : pick_next();
      if (ch >= 0) begin
        exp_snv       = m_valid[ch];
        exp_ready[ch] = sn_req_ready;
      end
    end
    checkOutput("req_ready", 256'(m_req_ready), 256'(exp_ready));
    checkOutput("sn_req_valid", 256'(sn_req_valid), 256'(exp_snv));
    if (exp_snv) checkOutput("sn_req", 256'(sn_req), 256'(m_req[ch]));
    checkOutput("resp_valid", 256'(m_resp_valid), 256'(exp_rvalid));
    checkOutput("sn_resp_ready", 256'(sn_resp_ready), 256'(exp_srr));
    checkOutput("resp_copy", 256'({m_resp[0], m_resp[1], m_resp[2], m_resp[3]}), 256'({4{sn_resp}}));

    if (busy) begin
      if (sn_resp_valid && m_resp_ready[owner] && sn_resp.resp_last) busy = 1'b0;
    end else if (ch >= 0 && m_valid[ch]) begin
      owner = ch;
      if (sn_req_ready) begin
        busy        = 1'b1;
        locked      = 1'b0;
        last_served = ch;
        accepted    = ch;
      end else begin
        locked = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_sn_req_valid"}, 256'(sn_req_valid), 256'(1'b0));
    checkOutput({tag, "_req_ready"}, 256'(m_req_ready), 256'(4'b0));
    checkOutput({tag, "_resp_valid"}, 256'(m_resp_valid), 256'(4'b0));
    checkOutput({tag, "_sn_resp_ready"}, 256'(sn_resp_ready), 256'(1'b0));
  endtask

  initial begin
    int expected_order [5];
`ifdef DMEM_NOC_ARB_FIXED_PRIO_EN
    expected_order = '{0, 0, 0, 0, 0};
`else
    expected_order = '{0, 1, 2, 3, 0};
`endif
    rstn          = 1'b0;
    m_valid       = '0;
    m_resp_ready  = '0;
    sn_req_ready  = 1'b0;
    sn_resp_valid = 1'b0;
    sn_resp       = {$urandom(), 2'b01};
    for (int i = 0; i < 4; i++) m_req[i] = rand_req();
    model_reset();
    #3;
    check_reset_outputs("init");
    checkOutput("init_resp_copy", 256'(m_resp[2]), 256'(sn_resp));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      applyStimulus(cyc < CONTENTION_CYCLES);
      if (cyc >= CONTENTION_CYCLES && busy && $urandom_range(0, 99) < 3) begin
        #1;
        rstn          = 1'b0;
        m_valid       = '0;
        sn_resp_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
      end else begin
        @(negedge clk);
        if (cyc < CONTENTION_CYCLES && sn_req_valid && sn_req_ready) begin
          for (int i = 0; i < 4; i++) if (m_req_ready[i]) grant_log.push_back(i);
        end
        model_check_and_step();
      end
      if (cyc == CONTENTION_CYCLES - 1) begin
        checkOutput("grant_count_ok", 256'(grant_log.size() >= 5), 256'(1'b1));
        for (int g = 0; g < 5; g++) begin
          if (g < grant_log.size())
            checkOutput($sformatf("grant_order%0d", g), 256'(grant_log[g]), 256'(expected_order[g]));
        end
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
